// File: rtl/pipe_hazard_scoreboard_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_hazard_scoreboard_if
// Brief   : Stage-info and hazard-control bundle between datapath and hazard unit
// Revision: 1.0 initial release
// ---------------------------------------------------------------------------
interface pipe_hazard_scoreboard_if #(
  parameter int NSRC  = 3,
  parameter int RW    = 4,
  parameter int CNT_W = 32
);
  logic                 valid_d;
  logic [NSRC*RW-1:0]   ra_d;
  logic [NSRC-1:0]      src_use_d;
  logic [RW-1:0]        rd_d;
  logic                 regwrite_d;
  logic                 long_d;
  logic                 pcsrc_d;
  logic [NSRC*RW-1:0]   ra_e;
  logic [RW-1:0]        rd_e;
  logic                 regwrite_e;
  logic                 memtoreg_e;
  logic                 pcsrc_e;
  logic                 branch_taken_e;
  logic [RW-1:0]        rd_m;
  logic                 regwrite_m;
  logic                 pcsrc_m;
  logic [RW-1:0]        rd_w;
  logic                 regwrite_w;
  logic                 pcsrc_w;
  logic [2*NSRC-1:0]    fwd_e;
  logic                 stall_f;
  logic                 stall_d;
  logic                 flush_d;
  logic                 flush_e;
  logic                 long_busy;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output valid_d, ra_d, src_use_d, rd_d, regwrite_d, long_d, pcsrc_d,
    output ra_e, rd_e, regwrite_e, memtoreg_e, pcsrc_e, branch_taken_e,
    output rd_m, regwrite_m, pcsrc_m, rd_w, regwrite_w, pcsrc_w,
    input  fwd_e, stall_f, stall_d, flush_d, flush_e, long_busy, stall_cnt
  );

  modport slave (
    input  valid_d, ra_d, src_use_d, rd_d, regwrite_d, long_d, pcsrc_d,
    input  ra_e, rd_e, regwrite_e, memtoreg_e, pcsrc_e, branch_taken_e,
    input  rd_m, regwrite_m, pcsrc_m, rd_w, regwrite_w, pcsrc_w,
    output fwd_e, stall_f, stall_d, flush_d, flush_e, long_busy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_hazard_scoreboard
// Brief   : 5-stage hazard/forwarding unit with long-op scoreboard and stall counter
// Revision: 1.0 initial release
// ---------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int NSRC       = 3,
  parameter int RW         = 4,
  parameter int PC_REG     = 15,
  parameter int LONG_LAT   = 4,
  parameter int LONG_SLOTS = 2,
  parameter int CNT_W      = 32
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  pipe_hazard_scoreboard_if.slave   hz
);

  localparam int          CW   = $clog2(LONG_LAT + 1);
  localparam logic [RW-1:0] c_pc = RW'(PC_REG);

  logic [RW-1:0]         r_rd  [LONG_SLOTS];
  logic [CW-1:0]         r_cnt [LONG_SLOTS];
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [2*NSRC-1:0]     w_fwd;
  logic                  w_ldstall;
  logic                  w_sbstall;
  logic                  w_any_free;
  logic                  w_all_busy;
  logic                  w_found;
  logic [LONG_SLOTS-1:0] w_sel;
  logic                  w_pcwpend;
  logic                  w_stall_d;
  logic                  w_flush_d;
  logic                  w_issue;

  function automatic logic hit_d(input logic [RW-1:0]      r,
                                 input logic [NSRC*RW-1:0] ra,
                                 input logic [NSRC-1:0]    use_v,
                                 input logic               v);
    logic h;
    h = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (use_v[i] && ra[i*RW +: RW] == r && r != c_pc) h = 1'b1;
    end
    return h & v;
  endfunction

  // M-stage result is the younger one, so it takes priority over W.
  always_comb begin
    w_fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.regwrite_m && hz.rd_m == hz.ra_e[i*RW +: RW] && hz.ra_e[i*RW +: RW] != c_pc)
        w_fwd[2*i +: 2] = 2'b10;
      else if (hz.regwrite_w && hz.rd_w == hz.ra_e[i*RW +: RW] && hz.ra_e[i*RW +: RW] != c_pc)
        w_fwd[2*i +: 2] = 2'b01;
    end
  end

  assign w_ldstall = hz.memtoreg_e & hz.regwrite_e &
                     hit_d(hz.rd_e, hz.ra_d, hz.src_use_d, hz.valid_d);

  // A slot's result becomes readable once cnt drops to 1; the slot itself
  // frees only at cnt==0, one cycle later.
  always_comb begin
    w_sbstall  = 1'b0;
    w_any_free = 1'b0;
    w_all_busy = 1'b1;
    w_found    = 1'b0;
    w_sel      = '0;
    for (int s = 0; s < LONG_SLOTS; s++) begin
      if (r_cnt[s] > CW'(1)) begin
        if (hit_d(r_rd[s], hz.ra_d, hz.src_use_d, hz.valid_d) ||
            (hz.regwrite_d && hz.rd_d == r_rd[s] && r_rd[s] != c_pc))
          w_sbstall = 1'b1;
      end
      if (r_cnt[s] == '0) begin
        w_any_free = 1'b1;
        if (!w_found) begin
          w_sel[s] = 1'b1;
          w_found  = 1'b1;
        end
      end else begin
        w_all_busy = w_all_busy;
      end
      if (r_cnt[s] == '0) w_all_busy = 1'b0;
    end
    if (hz.long_d && !w_any_free) w_sbstall = 1'b1;
    w_sbstall = w_sbstall & hz.valid_d;
  end

  assign w_pcwpend = hz.pcsrc_d | hz.pcsrc_e | hz.pcsrc_m;
  assign w_stall_d = ~reset & (w_ldstall | w_sbstall);
  assign w_flush_d = reset | w_pcwpend | hz.pcsrc_w | hz.branch_taken_e;
  assign w_issue   = hz.valid_d & hz.long_d & ~w_stall_d & ~w_flush_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < LONG_SLOTS; s++) begin
        r_rd[s]  <= '0;
        r_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LONG_SLOTS; s++) begin
        if (w_issue && w_sel[s]) begin
          r_rd[s]  <= hz.rd_d;
          r_cnt[s] <= CW'(LONG_LAT);
        end else if (r_cnt[s] != '0) begin
          r_cnt[s] <= r_cnt[s] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_stall_d && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign hz.fwd_e     = reset ? '0 : w_fwd;
  assign hz.stall_d   = w_stall_d;
  assign hz.stall_f   = ~reset & (w_ldstall | w_sbstall | w_pcwpend);
  assign hz.flush_e   = reset | w_ldstall | w_sbstall | hz.branch_taken_e;
  assign hz.flush_d   = w_flush_d;
  assign hz.long_busy = ~reset & w_all_busy;
  assign hz.stall_cnt = reset ? '0 : r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pipe_hazard_scoreboard
// Brief   : Directed and random checks of the hazard unit against a timeline model
// Revision: 1.0 initial release
// ---------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;
  localparam int NSRC  = 3;
  localparam int RW    = 4;
  localparam int PCR   = 15;
  localparam int LAT   = 4;
  localparam int SLOTS = 2;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_scoreboard_if #(.NSRC(NSRC), .RW(RW), .CNT_W(CW)) hz();

  pipe_hazard_scoreboard #(
    .NSRC(NSRC), .RW(RW), .PC_REG(PCR), .LONG_LAT(LAT),
    .LONG_SLOTS(SLOTS), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: each slot remembers the cycle its op issued; occupancy and
  // readability follow from elapsed time.
  int          cyc = 0;
  int          ic  [SLOTS];
  logic [3:0]  srd [SLOTS];
  int          m_scnt = 0;

  function automatic bit busy(int s);
    return (cyc > ic[s]) && (cyc <= ic[s] + LAT);
  endfunction

  function automatic bit haz(int s);
    return (cyc > ic[s]) && (cyc < ic[s] + LAT);
  endfunction

  function automatic bit hitd(logic [3:0] r);
    if (!hz.valid_d || r == 4'(PCR)) return 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (hz.src_use_d[i] && hz.ra_d[i*RW +: RW] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle();
    hz.valid_d = 0; hz.ra_d = '0; hz.src_use_d = '0; hz.rd_d = '0;
    hz.regwrite_d = 0; hz.long_d = 0; hz.pcsrc_d = 0;
    hz.ra_e = '0; hz.rd_e = '0; hz.regwrite_e = 0; hz.memtoreg_e = 0;
    hz.pcsrc_e = 0; hz.branch_taken_e = 0;
    hz.rd_m = '0; hz.regwrite_m = 0; hz.pcsrc_m = 0;
    hz.rd_w = '0; hz.regwrite_w = 0; hz.pcsrc_w = 0;
  endtask

  task automatic src_d(int i, logic [3:0] r);
    hz.ra_d[i*RW +: RW] = r;
    hz.src_use_d[i] = 1'b1;
  endtask

  // Compare every output against the model for this cycle, then advance the model.
  task automatic sample();
    logic [5:0] efwd;
    logic [3:0] r;
    bit ld, sb, allb, pcw, e_sd, e_sf, e_fd, e_fe, found;
    int ecnt;
    #3;
    efwd = '0;
    if (reset) begin
      e_sd = 0; e_sf = 0; e_fd = 1; e_fe = 1; allb = 0; ecnt = 0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        r = hz.ra_e[i*RW +: RW];
        if (r != 4'(PCR) && hz.regwrite_m && hz.rd_m == r) efwd[2*i +: 2] = 2'b10;
        else if (r != 4'(PCR) && hz.regwrite_w && hz.rd_w == r) efwd[2*i +: 2] = 2'b01;
      end
      allb = 1;
      for (int s = 0; s < SLOTS; s++) allb &= busy(s);
      ld = hz.memtoreg_e && hz.regwrite_e && hitd(hz.rd_e);
      sb = 0;
      for (int s = 0; s < SLOTS; s++)
        if (haz(s) && (hitd(srd[s]) ||
            (hz.regwrite_d && hz.rd_d == srd[s] && srd[s] != 4'(PCR)))) sb = 1;
      if (hz.long_d && allb) sb = 1;
      sb = sb && hz.valid_d;
      pcw  = hz.pcsrc_d | hz.pcsrc_e | hz.pcsrc_m;
      e_sd = ld | sb;
      e_sf = e_sd | pcw;
      e_fe = e_sd | hz.branch_taken_e;
      e_fd = pcw | hz.pcsrc_w | hz.branch_taken_e;
      ecnt = (m_scnt > 63) ? 63 : m_scnt;
    end
    chk("fwd_e",     64'(hz.fwd_e),     64'(efwd));
    chk("stall_d",   64'(hz.stall_d),   64'(e_sd));
    chk("stall_f",   64'(hz.stall_f),   64'(e_sf));
    chk("flush_d",   64'(hz.flush_d),   64'(e_fd));
    chk("flush_e",   64'(hz.flush_e),   64'(e_fe));
    chk("long_busy", 64'(hz.long_busy), 64'(allb));
    chk("stall_cnt", 64'(hz.stall_cnt), 64'(ecnt));
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) ic[s] = -1000;
      m_scnt = 0;
    end else begin
      if (e_sd) m_scnt++;
      if (hz.valid_d && hz.long_d && !e_sd && !e_fd) begin
        found = 0;
        for (int s = 0; s < SLOTS; s++)
          if (!found && !busy(s)) begin
            ic[s] = cyc; srd[s] = hz.rd_d; found = 1;
          end
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; sample(); step(); reset = 0;
  endtask

  task automatic mul(logic [3:0] r);
    idle(); hz.valid_d = 1; hz.long_d = 1; hz.regwrite_d = 1; hz.rd_d = r;
  endtask

  function automatic logic [3:0] rreg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 4'(PCR) : 4'(k);
  endfunction

  initial begin
    for (int s = 0; s < SLOTS; s++) begin ic[s] = -1000; srd[s] = '0; end
    idle(); reset = 1;
    step();
    sample();
    chk("rst_flush_d", 64'(hz.flush_d), 64'd1);
    chk("rst_flush_e", 64'(hz.flush_e), 64'd1);
    chk("rst_stall_f", 64'(hz.stall_f), 64'd0);
    step(); reset = 0;

    // Forward priority: M beats W; PC never forwarded.
    idle(); hz.regwrite_m = 1; hz.rd_m = 3; hz.regwrite_w = 1; hz.rd_w = 3;
    hz.ra_e[3:0] = 3;
    sample(); chk("fwd_m_over_w", 64'(hz.fwd_e[1:0]), 64'd2); step();
    idle(); hz.regwrite_m = 1; hz.rd_m = 15; hz.ra_e[3:0] = 15;
    sample(); chk("fwd_pc", 64'(hz.fwd_e[1:0]), 64'd0); step();

    // Load-use: one bubble.
    do_reset();
    idle(); hz.memtoreg_e = 1; hz.regwrite_e = 1; hz.rd_e = 2; hz.valid_d = 1; src_d(1, 2);
    sample();
    chk("lu_stall_f", 64'(hz.stall_f), 64'd1);
    chk("lu_stall_d", 64'(hz.stall_d), 64'd1);
    chk("lu_flush_e", 64'(hz.flush_e), 64'd1);
    step();
    idle(); hz.valid_d = 1; src_d(1, 2);
    sample();
    chk("lu_release", 64'(hz.stall_d), 64'd0);
    chk("lu_cnt", 64'(hz.stall_cnt), 64'd1);
    step();

    // Long op then dependent reader.
    do_reset();
    mul(4); sample(); chk("mul_issue", 64'(hz.stall_d), 64'd0); step();
    for (int k = 1; k <= 3; k++) begin
      idle(); hz.valid_d = 1; src_d(0, 4);
      sample(); chk("mul_dep_stall", 64'(hz.stall_d), 64'd1); step();
    end
    idle(); hz.valid_d = 1; src_d(0, 4);
    sample(); chk("mul_dep_go", 64'(hz.stall_d), 64'd0); step();
    idle(); sample(); chk("mul_cnt", 64'(hz.stall_cnt), 64'd3); step();

    // All slots full.
    do_reset();
    mul(5); sample(); step();
    mul(6); sample(); step();
    for (int k = 2; k <= 4; k++) begin
      mul(7); sample();
      chk("full_stall", 64'(hz.stall_d), 64'd1);
      chk("full_busy", 64'(hz.long_busy), 64'd1);
      step();
    end
    mul(7); sample();
    chk("full_go", 64'(hz.stall_d), 64'd0);
    chk("full_free", 64'(hz.long_busy), 64'd0);
    step();

    // PC write walking down the pipe.
    do_reset();
    idle(); hz.valid_d = 1; hz.pcsrc_d = 1; sample();
    chk("pc_d_flush", 64'(hz.flush_d), 64'd1); chk("pc_d_sf", 64'(hz.stall_f), 64'd1); step();
    idle(); hz.pcsrc_e = 1; sample(); chk("pc_e_sf", 64'(hz.stall_f), 64'd1); step();
    idle(); hz.pcsrc_m = 1; sample(); chk("pc_m_sf", 64'(hz.stall_f), 64'd1); step();
    idle(); hz.pcsrc_w = 1; sample();
    chk("pc_w_flush", 64'(hz.flush_d), 64'd1); chk("pc_w_sf", 64'(hz.stall_f), 64'd0); step();

    // Branch taken coinciding with load-use.
    idle(); hz.memtoreg_e = 1; hz.regwrite_e = 1; hz.rd_e = 2; hz.valid_d = 1; src_d(1, 2);
    hz.branch_taken_e = 1; sample();
    chk("br_ld_flush_d", 64'(hz.flush_d), 64'd1);
    chk("br_ld_flush_e", 64'(hz.flush_e), 64'd1);
    chk("br_ld_stall_d", 64'(hz.stall_d), 64'd1);
    step();

    // Reset while long ops are pending discards them.
    do_reset();
    mul(4); sample(); step();
    mul(9); sample(); step();
    idle(); sample(); chk("mid_busy", 64'(hz.long_busy), 64'd1); step();
    idle(); reset = 1; sample(); chk("mid_rst_busy", 64'(hz.long_busy), 64'd0); step();
    reset = 0;
    idle(); hz.valid_d = 1; src_d(0, 4); sample();
    chk("mid_no_stall", 64'(hz.stall_d), 64'd0);
    chk("mid_busy_clr", 64'(hz.long_busy), 64'd0);
    step();

    // Random traffic over a small register set to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      hz.valid_d    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NSRC; i++) begin
        hz.ra_d[i*RW +: RW] = rreg();
        hz.ra_e[i*RW +: RW] = rreg();
      end
      hz.src_use_d  = 3'($urandom);
      hz.rd_d       = rreg();
      hz.regwrite_d = $urandom_range(0, 1);
      hz.long_d     = ($urandom_range(0, 9) < 4);
      hz.pcsrc_d    = ($urandom_range(0, 19) == 0);
      hz.rd_e       = rreg();
      hz.regwrite_e = $urandom_range(0, 1);
      hz.memtoreg_e = ($urandom_range(0, 3) == 0);
      hz.pcsrc_e    = ($urandom_range(0, 19) == 0);
      hz.branch_taken_e = ($urandom_range(0, 9) == 0);
      hz.rd_m       = rreg();
      hz.regwrite_m = $urandom_range(0, 1);
      hz.pcsrc_m    = ($urandom_range(0, 19) == 0);
      hz.rd_w       = rreg();
      hz.regwrite_w = $urandom_range(0, 1);
      hz.pcsrc_w    = ($urandom_range(0, 19) == 0);
      sample();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
